order_decoder: RTL

Serial-to-parallel order register and function decoder for the EDSAC control section. During the order-fetch stage it captures the 17-bit order word arriving least-significant-digit first from the store and holds it for the execute stage. It decodes the 5-bit function field into the one-hot `op_*` lines that feed the order coder, and presents the address field and long/short flag to the store address logic.

---
 rtl/order_decoder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/order_decoder.sv
// EDSAC order register: captures a 17-bit serial order word (LSB first) during
// order fetch, holds it for execute and decodes the function field one-hot.
module order_decoder #(
   parameter int WORD_BITS = 17,
   parameter int MC_DIGITS = 18
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mc_sync,
   input  logic       fetch,
   input  logic       order_bit,
   output logic       order_valid,
   output logic       busy,
   output logic [9:0] addr,
   output logic       long_order,
   output logic       op_p,
   output logic       op_q,
   output logic       op_w,
   output logic       op_e,
   output logic       op_r,
   output logic       op_t,
   output logic       op_y,
   output logic       op_u,
   output logic       op_i,
   output logic       op_o,
   output logic       op_j,
   output logic       op_pi,
   output logic       op_s,
   output logic       op_z,
   output logic       op_k,
   output logic       op_erase,
   output logic       op_blank,
   output logic       op_f,
   output logic       op_theta,
   output logic       op_d,
   output logic       op_phi,
   output logic       op_h,
   output logic       op_n,
   output logic       op_m,
   output logic       op_delta,
   output logic       op_l,
   output logic       op_x,
   output logic       op_g,
   output logic       op_a,
   output logic       op_b,
   output logic       op_c,
   output logic       op_v
);

   localparam logic [4:0] LAST_DIGIT = 5'(MC_DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t               state_r;
   logic [4:0]           digit_r;
   logic [4:0]           digit_s;
   logic                 start_s;
   logic [WORD_BITS-1:0] shift_r;
   logic [31:0]          op_vec_r;
   logic [9:0]           addr_r;
   logic                 long_r;
   logic                 order_valid_r;
   logic                 busy_r;

   function automatic logic [31:0] decode_fn(input logic [4:0] func);
      decode_fn = 32'd1 << func;
   endfunction

   // Digit position of the current cycle; mc_sync forces digit 0.
   always_comb begin
      if (mc_sync) begin
         digit_s = 5'd0;
      end else begin
         digit_s = digit_r;
      end
      start_s = mc_sync & fetch;
   end

   // Capture FSM, digit counter, shift register and held-order outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         digit_r       <= 5'd0;
         shift_r       <= '0;
         op_vec_r      <= 32'd0;
         addr_r        <= 10'd0;
         long_r        <= 1'b0;
         order_valid_r <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         digit_r <= (digit_s == LAST_DIGIT) ? 5'd0 : digit_s + 5'd1;
         if (start_s) begin
            // Bit 0 arrives on the mc_sync cycle; any partial word is dropped.
            state_r       <= SHIFT;
            busy_r        <= 1'b1;
            order_valid_r <= 1'b0;
            op_vec_r      <= 32'd0;
            shift_r       <= {order_bit, {(WORD_BITS-1){1'b0}}};
         end else begin
            case (state_r)
               SHIFT: begin
                  if (mc_sync) begin
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                     shift_r <= '0;
                  end else if (digit_s == LAST_DIGIT) begin
                     state_r       <= HOLD;
                     busy_r        <= 1'b0;
                     order_valid_r <= 1'b1;
                     op_vec_r      <= decode_fn(shift_r[16:12]);
                     addr_r        <= shift_r[10:1];
                     long_r        <= shift_r[0];
                  end else begin
                     shift_r <= {order_bit, shift_r[WORD_BITS-1:1]};
                  end
               end
               IDLE:    state_r <= IDLE;
               HOLD:    state_r <= HOLD;
               default: state_r <= IDLE;
            endcase
         end
      end
   end

   assign order_valid = order_valid_r;
   assign busy        = busy_r;
   assign addr        = addr_r;
   assign long_order  = long_r;

   assign op_p     = op_vec_r[0];
   assign op_q     = op_vec_r[1];
   assign op_w     = op_vec_r[2];
   assign op_e     = op_vec_r[3];
   assign op_r     = op_vec_r[4];
   assign op_t     = op_vec_r[5];
   assign op_y     = op_vec_r[6];
   assign op_u     = op_vec_r[7];
   assign op_i     = op_vec_r[8];
   assign op_o     = op_vec_r[9];
   assign op_j     = op_vec_r[10];
   assign op_pi    = op_vec_r[11];
   assign op_s     = op_vec_r[12];
   assign op_z     = op_vec_r[13];
   assign op_k     = op_vec_r[14];
   assign op_erase = op_vec_r[15];
   assign op_blank = op_vec_r[16];
   assign op_f     = op_vec_r[17];
   assign op_theta = op_vec_r[18];
   assign op_d     = op_vec_r[19];
   assign op_phi   = op_vec_r[20];
   assign op_h     = op_vec_r[21];
   assign op_n     = op_vec_r[22];
   assign op_m     = op_vec_r[23];
   assign op_delta = op_vec_r[24];
   assign op_l     = op_vec_r[25];
   assign op_x     = op_vec_r[26];
   assign op_g     = op_vec_r[27];
   assign op_a     = op_vec_r[28];
   assign op_b     = op_vec_r[29];
   assign op_c     = op_vec_r[30];
   assign op_v     = op_vec_r[31];

endmodule
